// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for the programmable clock divider: accepts (ratio, enable)
// settings over valid/ready and commits them only on divided-period boundaries.
module clk_div_cfg_ctrl #(
   parameter int RATIO_WIDTH = 5
) (
   input  logic                   i_ref_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cfg_valid,
   output logic                   o_cfg_ready,
   input  logic [RATIO_WIDTH-1:0] i_cfg_ratio,
   input  logic                   i_cfg_en,
   output logic [RATIO_WIDTH-1:0] o_div_ratio,
   output logic                   o_clk_en,
   output logic                   o_period_tick,
   output logic                   o_busy
);

   localparam logic [RATIO_WIDTH-1:0] RATIO_ONE = RATIO_WIDTH'(1);

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   state_t                 state_q, state_d;
   logic [RATIO_WIDTH-1:0] shadowRatio_q, shadowRatio_d;
   logic                   shadowEn_q, shadowEn_d;
   logic [RATIO_WIDTH-1:0] divRatio_q, divRatio_d;
   logic                   clkEn_q, clkEn_d;
   logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
   logic                   tick_q, tick_d;

   logic activeMode;
   logic periodEnd;
   logic commit;

   // In bypass the divider forwards the reference clock, so any edge is a safe commit point.
   assign activeMode = clkEn_q && (divRatio_q > RATIO_ONE);
   assign periodEnd  = activeMode && (cnt_q == divRatio_q);
   assign commit     = (state_q == PENDING) && (!activeMode || periodEnd);

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         shadowRatio_q <= '0;
         shadowEn_q    <= 1'b0;
         divRatio_q    <= RATIO_ONE;
         clkEn_q       <= 1'b0;
         cnt_q         <= RATIO_ONE;
         tick_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadowRatio_q <= shadowRatio_d;
         shadowEn_q    <= shadowEn_d;
         divRatio_q    <= divRatio_d;
         clkEn_q       <= clkEn_d;
         cnt_q         <= cnt_d;
         tick_q        <= tick_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shadowRatio_d = shadowRatio_q;
      shadowEn_d    = shadowEn_q;
      case (state_q)
         IDLE: begin
            if (i_cfg_valid) begin
               shadowRatio_d = i_cfg_ratio;
               shadowEn_d    = i_cfg_en;
               state_d       = PENDING;
            end
         end
         PENDING: begin
            if (commit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A commit on a wrap edge takes over the wrap: the counter restarts and the tick still fires.
   always_comb begin
      divRatio_d = divRatio_q;
      clkEn_d    = clkEn_q;
      tick_d     = periodEnd;
      if (commit) begin
         divRatio_d = shadowRatio_q;
         clkEn_d    = shadowEn_q;
         cnt_d      = RATIO_ONE;
      end else if (activeMode && !periodEnd) begin
         cnt_d = cnt_q + RATIO_ONE;
      end else begin
         cnt_d = RATIO_ONE;
      end
   end

   always_comb begin
      o_cfg_ready = 1'b0;
      o_busy      = 1'b0;
      case (state_q)
         IDLE:    o_cfg_ready = 1'b1;
         PENDING: o_busy      = 1'b1;
         default: o_cfg_ready = 1'b0;
      endcase
   end

   assign o_div_ratio   = divRatio_q;
   assign o_clk_en      = clkEn_q;
   assign o_period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: a per-cycle vector table for bypass/active
// commits, then hand-written sequences for disable, bypass ratios, held valid and reset.
module tb_clk_div_cfg_ctrl;

   localparam int RW = 5;

   logic          refClk;
   logic          rstN;
   logic          cfgValid;
   logic          cfgReady;
   logic [RW-1:0] cfgRatio;
   logic          cfgEn;
   logic [RW-1:0] divRatio;
   logic          clkEn;
   logic          periodTick;
   logic          busy;

   int checks;
   int failures;

   typedef struct {
      logic          valid;
      logic [RW-1:0] ratio;
      logic          en;
      logic [RW-1:0] expRatio;
      logic          expEn;
      logic          expTick;
      logic          expBusy;
      logic          expReady;
   } vec_t;

   vec_t vecs[$];

   clk_div_cfg_ctrl #(.RATIO_WIDTH(RW)) dut (
      .i_ref_clk    (refClk),
      .i_rst_n      (rstN),
      .i_cfg_valid  (cfgValid),
      .o_cfg_ready  (cfgReady),
      .i_cfg_ratio  (cfgRatio),
      .i_cfg_en     (cfgEn),
      .o_div_ratio  (divRatio),
      .o_clk_en     (clkEn),
      .o_period_tick(periodTick),
      .o_busy       (busy)
   );

   // Free-running reference clock, rising edges at 5, 15, 25, ...
   initial begin
      refClk = 1'b0;
      forever #5 refClk = ~refClk;
   end

   // Compares one observed value against its expected value and logs any difference.
   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, lets a rising edge pass, then checks all outputs.
   task automatic applyStimulus(input logic v, input logic [RW-1:0] r, input logic e,
                                input logic [RW-1:0] expR, input logic expE, input logic expT,
                                input logic expB, input logic expRdy, input string tag);
      cfgValid = v;
      cfgRatio = r;
      cfgEn    = e;
      @(posedge refClk);
      #1;
      checkOutput({tag, ".ratio"}, 8'(divRatio), 8'(expR));
      checkOutput({tag, ".en"},    8'(clkEn),    8'(expE));
      checkOutput({tag, ".tick"},  8'(periodTick), 8'(expT));
      checkOutput({tag, ".busy"},  8'(busy),     8'(expB));
      checkOutput({tag, ".ready"}, 8'(cfgReady), 8'(expRdy));
   endtask

   function automatic vec_t mk(logic v, logic [RW-1:0] r, logic e, logic [RW-1:0] er,
                               logic ee, logic et, logic eb, logic erd);
      vec_t x;
      x.valid = v; x.ratio = r; x.en = e; x.expRatio = er;
      x.expEn = ee; x.expTick = et; x.expBusy = eb; x.expReady = erd;
      return x;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      cfgValid = 1'b0;
      cfgRatio = '0;
      cfgEn    = 1'b0;
      rstN     = 1'b0;

      // Bypass accept of ratio 4, ticks every 4 cycles, then ratio 6 requested at cnt=2.
      vecs.push_back(mk(1, 4, 1, 1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 0, 1));
      vecs.push_back(mk(1, 6, 1, 4, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 6, 1, 1, 0, 1));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 6, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 6, 1, 1, 0, 1));

      #12;
      checkOutput("rst.ratio", 8'(divRatio), 8'd1);
      checkOutput("rst.en",    8'(clkEn),    8'd0);
      checkOutput("rst.tick",  8'(periodTick), 8'd0);
      checkOutput("rst.busy",  8'(busy),     8'd0);
      checkOutput("rst.ready", 8'(cfgReady), 8'd1);
      rstN = 1'b1;
      @(posedge refClk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].valid, vecs[i].ratio, vecs[i].en, vecs[i].expRatio,
                       vecs[i].expEn, vecs[i].expTick, vecs[i].expBusy, vecs[i].expReady,
                       $sformatf("vec%0d", i));
      end

      // Active at 6 with cnt=1: ratio 5 commits only when cnt reaches 6.
      applyStimulus(1, 5, 1, 6, 1, 0, 1, 0, "r5.acc");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 6, 1, 0, 1, 0, "r5.wait");
      applyStimulus(0, 0, 0, 5, 1, 1, 0, 1, "r5.commit");

      // Disable waits for the ratio-5 boundary; no ticks afterwards.
      applyStimulus(1, 5, 0, 5, 1, 0, 1, 0, "dis.acc");
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 5, 1, 0, 1, 0, "dis.wait");
      applyStimulus(0, 0, 0, 5, 0, 1, 0, 1, "dis.commit");
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 5, 0, 0, 0, 1, "dis.quiet");

      // Ratios 0 and 1 commit one cycle after accept and never tick.
      applyStimulus(1, 0, 1, 5, 0, 0, 1, 0, "r0.acc");
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, "r0.commit");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, "r0.quiet");
      applyStimulus(1, 1, 1, 0, 1, 0, 1, 0, "r1.acc");
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 1, "r1.commit");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0, 1, "r1.quiet");

      // Valid held through PENDING with changing data; only accept-edge data commits.
      applyStimulus(1, 9, 1, 1, 1, 0, 1, 0, "hold.acc");
      applyStimulus(1, 12, 0, 9, 1, 0, 0, 1, "hold.commit");
      applyStimulus(1, 12, 0, 9, 1, 0, 1, 0, "hold.acc2");
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 9, 1, 0, 1, 0, "hold.wait");
      applyStimulus(0, 0, 0, 12, 0, 1, 0, 1, "hold.commit2");

      // Re-enable from bypass: first tick exactly 3 cycles after commit shows cnt held at 1.
      applyStimulus(1, 3, 1, 12, 0, 0, 1, 0, "re.acc");
      applyStimulus(0, 0, 0, 3, 1, 0, 0, 1, "re.commit");
      applyStimulus(0, 0, 0, 3, 1, 0, 0, 1, "re.c2");
      applyStimulus(0, 0, 0, 3, 1, 0, 0, 1, "re.c3");
      applyStimulus(0, 0, 0, 3, 1, 1, 0, 1, "re.tick");

      // Reset while ratio 7 is pending: outputs drop at once and 7 never appears.
      applyStimulus(1, 7, 1, 3, 1, 0, 1, 0, "mid.acc");
      cfgValid = 1'b0;
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("mid.ratio", 8'(divRatio), 8'd1);
      checkOutput("mid.en",    8'(clkEn),    8'd0);
      checkOutput("mid.busy",  8'(busy),     8'd0);
      checkOutput("mid.ready", 8'(cfgReady), 8'd1);
      checkOutput("mid.tick",  8'(periodTick), 8'd0);
      @(posedge refClk);
      #1;
      rstN = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, "mid.after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_div_cfg_ctrl.md
Name: clk_div_cfg_ctrl

Overview:
- Upstream configuration stage for the programmable clock divider. It drives the divider's ratio and clock-enable inputs.
- Accepts new (ratio, enable) settings over a valid/ready handshake and holds them in a shadow register.
- Commits a setting only at a divided-period boundary, so the divider never sees a ratio or enable change mid-period and the divided clock never glitches.
- Also gives downstream logic a one-cycle period tick and a busy flag.

Parameters:
- RATIO_WIDTH, 5, width of the ratio fields; must match the divider's ratio width.

Ports:
- i_ref_clk  input  1  reference clock; same clock as the divider.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_cfg_valid  input  1  a new setting is presented.
- o_cfg_ready  output  1  block can accept a setting.
- i_cfg_ratio  input  RATIO_WIDTH  requested division ratio.
- i_cfg_en  input  1  requested divider enable.
- o_div_ratio  output  RATIO_WIDTH  committed ratio; drives the divider ratio input.
- o_clk_en  output  1  committed enable; drives the divider enable input.
- o_period_tick  output  1  one-cycle pulse per completed divided period.
- o_busy  output  1  a setting is pending commit.

Behaviour:
- Reset values (asynchronous, while i_rst_n=0):
  - o_div_ratio=1, o_clk_en=0, o_period_tick=0, o_busy=0, o_cfg_ready=1.
  - Internal counter cnt=1; state IDLE; shadow ratio/enable cleared.
- Mode definitions:
  - Active mode: o_clk_en=1 and o_div_ratio>=2.
  - Bypass mode: anything else (ratio 0 or 1, or enable low). The divider passes the reference clock through in bypass.
- Period counter cnt (RATIO_WIDTH bits):
  - Active mode: if cnt==o_div_ratio, cnt<=1, else cnt<=cnt+1. Odd and even ratios both count the full ratio in reference cycles per period.
  - Bypass mode: cnt held at 1.
- o_period_tick: registered. High for exactly one cycle after each edge where active mode and cnt==o_div_ratio. Never high in bypass.
- FSM state IDLE:
  - o_cfg_ready=1, o_busy=0.
  - On i_cfg_valid=1 at a rising edge: capture i_cfg_ratio and i_cfg_en into the shadow register; go to PENDING.
  - The setting captured is the one present on that edge.
- FSM state PENDING:
  - o_cfg_ready=0, o_busy=1. i_cfg_valid is ignored; the source must hold it until ready returns.
  - Commit edge:
    - Currently bypass: the first edge in PENDING, i.e. 1 cycle after the accept edge.
    - Currently active: the edge where cnt==o_div_ratio (period end).
  - On the commit edge: o_div_ratio<=shadow ratio, o_clk_en<=shadow enable, cnt<=1, state<=IDLE.
- Latency:
  - Accept to output update: 1 cycle when in bypass.
  - When active: the remaining cycles of the current period, between 1 and old ratio cycles.
- Ratio rules:
  - Ratios 0 and 1 are legal and committed unchanged; they produce bypass mode.
  - No saturation or other arithmetic is applied to the ratio.
- Boundary cases:
  - Disabling an active divider (i_cfg_en=0) also waits for the period boundary, so the final divided period is always complete.
  - A commit that lands on a wrap edge replaces the wrap: cnt<=1 and the tick still fires for the completed period.
  - Counter wrap at the maximum ratio (2^RATIO_WIDTH-1) needs no overflow handling, because cnt resets on equality.
  - Back-to-back settings: ready re-asserts the cycle after a commit, so a second accept is possible on the next edge.
- Reset mid-PENDING: discards the shadow setting; all outputs return to reset values immediately.

Test Plan:
- Reset, then write ratio=4, en=1 in bypass -> o_div_ratio=4 and o_clk_en=1 one cycle after the accept; o_period_tick pulses every 4 cycles; o_busy high for exactly 1 cycle.
- Active at ratio=4 with cnt=2, write ratio=6 -> o_busy high; o_div_ratio stays 4 until the edge where cnt==4, then becomes 6; subsequent ticks are 6 cycles apart with no short period.
- Active at ratio=5, write en=0 with ratio=5 -> o_clk_en falls only at the cnt==5 boundary; no ticks afterwards; cnt held at 1.
- Write ratio=0, en=1 and ratio=1, en=1 -> each committed 1 cycle after accept; o_period_tick stays 0.
- Hold i_cfg_valid through PENDING with changing data -> only data present on the accept edge is committed; the next accept occurs the cycle after o_cfg_ready re-asserts.
- Assert i_rst_n=0 mid-PENDING (ratio=7 pending) -> outputs immediately read ratio=1, en=0, busy=0, ready=1; after release, ratio 7 is never committed.
